bfly_add_pipe: RTL and testbench
================================

Name: bfly_add_pipe

Overview:
Parametrised, pipelined radix-2 butterfly add/subtract stage for the FFT BF_ALU. It takes LANES complex operand pairs per beat and produces sum and difference per lane. Valid/ready flow control allows it to sit between the twiddle multiplier and the stage memory under backpressure. An optional scale mode applies a round-and-saturate divide-by-2 so that bit growth stays bounded across FFT stages.

Parameters:
SIG, 1, sign bits
INT, 3, integer bits
FLT, 6, fractional bits
WIDTH, SIG+INT+FLT, input sample width (10 by default)
LANES, 16, complex lanes per beat
SCALE, 0, 0 = full precision (output grows 1 bit); 1 = round-half-up >>1 with saturation
OUT_W, (SCALE ? WIDTH : WIDTH+1), output width (derived localparam, not overridable)

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
din1_re / din1_im  in  signed [WIDTH-1:0] x LANES  operand 1, real / imaginary
din2_re / din2_im  in  signed [WIDTH-1:0] x LANES  operand 2, real / imaginary
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
dout1_re / dout1_im  out  signed [OUT_W-1:0] x LANES  din2 + din1
dout2_re / dout2_im  out  signed [OUT_W-1:0] x LANES  din2 - din1
ovf_sticky  out  1  saturation occurred since the last clear
ovf_clr  in  1  clears ovf_sticky

Behaviour:
- Clock and reset: clk, rstn. Single clock; reset is synchronous and active-low.
- Reset:
  - On a clk edge with rstn=0: out_valid=0, ovf_sticky=0, all data registers and all dout* = 0, internal stage valids = 0.
  - in_ready=1 on the first cycle after reset.
- Reset mid-operation: in-flight beats are discarded silently; no partial outputs.
- Pipeline, two register stages:
  - S1 registers the full-precision results: WIDTH+1-bit sign-extended sum and difference for every lane and component.
  - S2 registers the post-processed results (pass-through, or scale/round/saturate).
- Stage enables:
  - en2 = !v2 | out_ready.
  - en1 = !v1 | en2.
  - in_ready = en1 (combinational).
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Latency and throughput:
  - Latency is 2 cycles from input transfer to out_valid when there is no stall.
  - Throughput is 1 beat per cycle.
- Stalls and ordering:
  - While out_valid=1 and out_ready=0, dout* and out_valid hold stable.
  - The block holds at most 2 beats.
  - With both stages full and out_ready=0, in_ready=0.
  - No beat is dropped or duplicated; output order equals input order.
- Arithmetic:
  - sum = din2 + din1, diff = din2 - din1, both sign-extended to WIDTH+1 before the operation.
  - SCALE=0: output = sum/diff exactly.
  - SCALE=1, rounding: r = (x + 1) >>> 1 (arithmetic shift, round half up).
  - SCALE=1, saturation: if r > 2^(WIDTH-1)-1, output 2^(WIDTH-1)-1 and flag the lane. Negative results cannot underflow (min -2^WIDTH -> -2^(WIDTH-1)).
- ovf_sticky:
  - Set on the cycle a beat whose lane flag is set in any lane or component is loaded into S2.
  - ovf_clr=1 clears it.
  - Simultaneous set and clear: set wins.
  - When SCALE=0, ovf_sticky is tied to 0.
- in_valid may drop without a transfer; din* are ignored when in_valid=0.

Decomposition:
- Package bfly_pkg:
  - Width localparams (SIG, INT, FLT, WIDTH).
  - typedefs sample_t [WIDTH-1:0] and wide_t [WIDTH:0].
  - Saturation constant SAT_MAX = 2^(WIDTH-1)-1.
- Sub-module bfly_lane (combinational): one lane's add/sub plus round/saturate and flag, instantiated LANES times.
- The top level owns the stage registers, the handshake and ovf_sticky.

Test Plan:
1. Reset then single beat, SCALE=0, LANES=16, lane0 din1_re=100, din2_re=-30 -> 2 cycles later dout1_re[0]=70, dout2_re[0]=-130, out_valid for 1 cycle.
2. Extremes, SCALE=0: din1=-512, din2=511 -> dout1=-1, dout2=1023. din1=din2=-512 -> dout1=-1024, dout2=0.
3. SCALE=1: din1=-512, din2=511 -> dout2 saturates to 511 and ovf_sticky=1. din1=3, din2=4 -> dout1=4 ((7+1)>>1), dout2=1 ((1+1)>>1).
4. Backpressure: 5 back-to-back beats with out_ready=0 from cycle 3 -> in_ready=0 after 2 beats are held, dout stable. On release, all 5 beats emerge in order with no gaps.
5. Simultaneous ovf_clr=1 and a saturating beat entering S2 -> ovf_sticky=1. A later ovf_clr alone -> ovf_sticky=0.
6. rstn=0 for 1 cycle with 2 beats in flight -> out_valid=0, dout*=0, ovf_sticky=0 next cycle. The held beats never appear.

Source files
------------

// File: rtl/bfly_pkg.sv
// Shared widths, sample types and the round/saturate helper for the radix-2 butterfly stage.
package bfly_pkg;

    localparam int unsigned SIG   = 1;
    localparam int unsigned INT   = 3;
    localparam int unsigned FLT   = 6;
    localparam int unsigned WIDTH = SIG + INT + FLT;

    typedef logic signed [WIDTH-1:0] sample_t;
    typedef logic signed [WIDTH:0]   wide_t;

    localparam sample_t SAT_MAX = sample_t'((1 << (WIDTH - 1)) - 1);

    typedef struct packed {
        logic    ovf;
        sample_t val;
    } scaled_t;

    // Round half up, then halve. Only the positive side can exceed the output range.
    function automatic scaled_t round_sat(wide_t x);
        logic signed [WIDTH+1:0] r;
        scaled_t                 res;
        r       = (WIDTH + 2)'(x);
        r       = (r + (WIDTH + 2)'(1)) >>> 1;
        res.ovf = r > (WIDTH + 2)'(SAT_MAX);
        res.val = res.ovf ? SAT_MAX : r[WIDTH-1:0];
        return res;
    endfunction

endpackage

// File: rtl/bfly_lane.sv
// One complex butterfly lane: full-precision add/sub feeding S1, and the
// post-processing (pass-through or round/saturate) applied to the S1 values.
module bfly_lane
    import bfly_pkg::*;
#(
    parameter bit           SCALE = 1'b0,
    localparam int unsigned OUT_W = SCALE ? WIDTH : WIDTH + 1
) (
    input  sample_t                 din1_re,
    input  sample_t                 din1_im,
    input  sample_t                 din2_re,
    input  sample_t                 din2_im,
    output wide_t                   sum_re,
    output wide_t                   sum_im,
    output wide_t                   diff_re,
    output wide_t                   diff_im,
    input  wide_t                   s1_sum_re,
    input  wide_t                   s1_sum_im,
    input  wide_t                   s1_diff_re,
    input  wide_t                   s1_diff_im,
    output logic signed [OUT_W-1:0] post_sum_re,
    output logic signed [OUT_W-1:0] post_sum_im,
    output logic signed [OUT_W-1:0] post_diff_re,
    output logic signed [OUT_W-1:0] post_diff_im,
    output logic                    ovf
);

    assign sum_re  = wide_t'(din2_re) + wide_t'(din1_re);
    assign sum_im  = wide_t'(din2_im) + wide_t'(din1_im);
    assign diff_re = wide_t'(din2_re) - wide_t'(din1_re);
    assign diff_im = wide_t'(din2_im) - wide_t'(din1_im);

    if (SCALE) begin : g_scale
        scaled_t r_sum_re, r_sum_im, r_diff_re, r_diff_im;

        assign r_sum_re  = round_sat(s1_sum_re);
        assign r_sum_im  = round_sat(s1_sum_im);
        assign r_diff_re = round_sat(s1_diff_re);
        assign r_diff_im = round_sat(s1_diff_im);

        assign post_sum_re  = r_sum_re.val;
        assign post_sum_im  = r_sum_im.val;
        assign post_diff_re = r_diff_re.val;
        assign post_diff_im = r_diff_im.val;

        assign ovf = r_sum_re.ovf | r_sum_im.ovf | r_diff_re.ovf | r_diff_im.ovf;
    end else begin : g_full
        assign post_sum_re  = s1_sum_re;
        assign post_sum_im  = s1_sum_im;
        assign post_diff_re = s1_diff_re;
        assign post_diff_im = s1_diff_im;
        assign ovf          = 1'b0;
    end

endmodule

// File: rtl/bfly_add_pipe.sv
// Two-stage pipelined radix-2 butterfly add/sub over LANES complex lanes with
// valid/ready flow control and a sticky saturation flag.
module bfly_add_pipe
    import bfly_pkg::*;
#(
    parameter int unsigned  LANES = 16,
    parameter bit           SCALE = 1'b0,
    localparam int unsigned OUT_W = SCALE ? WIDTH : WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  sample_t                 din1_re  [LANES],
    input  sample_t                 din1_im  [LANES],
    input  sample_t                 din2_re  [LANES],
    input  sample_t                 din2_im  [LANES],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] dout1_re [LANES],
    output logic signed [OUT_W-1:0] dout1_im [LANES],
    output logic signed [OUT_W-1:0] dout2_re [LANES],
    output logic signed [OUT_W-1:0] dout2_im [LANES],
    output logic                    ovf_sticky,
    input  logic                    ovf_clr
);

    logic v1_q, v2_q, ovf_q;
    logic en1, en2;

    wide_t s1_sum_re_q  [LANES];
    wide_t s1_sum_im_q  [LANES];
    wide_t s1_diff_re_q [LANES];
    wide_t s1_diff_im_q [LANES];

    wide_t sum_re  [LANES];
    wide_t sum_im  [LANES];
    wide_t diff_re [LANES];
    wide_t diff_im [LANES];

    logic signed [OUT_W-1:0] post_sum_re  [LANES];
    logic signed [OUT_W-1:0] post_sum_im  [LANES];
    logic signed [OUT_W-1:0] post_diff_re [LANES];
    logic signed [OUT_W-1:0] post_diff_im [LANES];
    logic [LANES-1:0]        lane_ovf;

    // Each stage advances when it is empty or the stage after it is advancing.
    assign en2       = !v2_q || out_ready;
    assign en1       = !v1_q || en2;
    assign in_ready  = en1;
    assign out_valid = v2_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        bfly_lane #(
            .SCALE (SCALE)
        ) u_lane (
            .din1_re      (din1_re[l]),
            .din1_im      (din1_im[l]),
            .din2_re      (din2_re[l]),
            .din2_im      (din2_im[l]),
            .sum_re       (sum_re[l]),
            .sum_im       (sum_im[l]),
            .diff_re      (diff_re[l]),
            .diff_im      (diff_im[l]),
            .s1_sum_re    (s1_sum_re_q[l]),
            .s1_sum_im    (s1_sum_im_q[l]),
            .s1_diff_re   (s1_diff_re_q[l]),
            .s1_diff_im   (s1_diff_im_q[l]),
            .post_sum_re  (post_sum_re[l]),
            .post_sum_im  (post_sum_im[l]),
            .post_diff_re (post_diff_re[l]),
            .post_diff_im (post_diff_im[l]),
            .ovf          (lane_ovf[l])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            ovf_q <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                s1_sum_re_q[l]  <= '0;
                s1_sum_im_q[l]  <= '0;
                s1_diff_re_q[l] <= '0;
                s1_diff_im_q[l] <= '0;
                dout1_re[l]     <= '0;
                dout1_im[l]     <= '0;
                dout2_re[l]     <= '0;
                dout2_im[l]     <= '0;
            end
        end else begin
            if (en1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    for (int l = 0; l < LANES; l++) begin
                        s1_sum_re_q[l]  <= sum_re[l];
                        s1_sum_im_q[l]  <= sum_im[l];
                        s1_diff_re_q[l] <= diff_re[l];
                        s1_diff_im_q[l] <= diff_im[l];
                    end
                end
            end
            if (en2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    for (int l = 0; l < LANES; l++) begin
                        dout1_re[l] <= post_sum_re[l];
                        dout1_im[l] <= post_sum_im[l];
                        dout2_re[l] <= post_diff_re[l];
                        dout2_im[l] <= post_diff_im[l];
                    end
                end
            end
            // A saturating beat landing in S2 beats a concurrent clear.
            if (SCALE && en2 && v1_q && (|lane_ovf)) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign ovf_sticky = SCALE ? ovf_q : 1'b0;

endmodule

// File: tb/tb_bfly_add_pipe.sv
// Directed bench for bfly_add_pipe: one full-precision and one scaled instance share stimulus.
module tb_bfly_add_pipe;
    import bfly_pkg::*;

    localparam int unsigned LANES = 16;

    logic clk;
    logic rstn, in_valid, out_ready, ovf_clr;
    sample_t din1_re [LANES];
    sample_t din1_im [LANES];
    sample_t din2_re [LANES];
    sample_t din2_im [LANES];

    logic in_ready0, out_valid0, ovf0;
    logic signed [WIDTH:0] d0_sre [LANES];
    logic signed [WIDTH:0] d0_sim [LANES];
    logic signed [WIDTH:0] d0_dre [LANES];
    logic signed [WIDTH:0] d0_dim [LANES];

    logic in_ready1, out_valid1, ovf1;
    sample_t d1_sre [LANES];
    sample_t d1_sim [LANES];
    sample_t d1_dre [LANES];
    sample_t d1_dim [LANES];

    int n_checks;
    int n_errors;

    bfly_add_pipe #(
        .LANES (LANES),
        .SCALE (1'b0)
    ) u_dut0 (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready0),
        .din1_re    (din1_re),
        .din1_im    (din1_im),
        .din2_re    (din2_re),
        .din2_im    (din2_im),
        .out_valid  (out_valid0),
        .out_ready  (out_ready),
        .dout1_re   (d0_sre),
        .dout1_im   (d0_sim),
        .dout2_re   (d0_dre),
        .dout2_im   (d0_dim),
        .ovf_sticky (ovf0),
        .ovf_clr    (ovf_clr)
    );

    bfly_add_pipe #(
        .LANES (LANES),
        .SCALE (1'b1)
    ) u_dut1 (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready1),
        .din1_re    (din1_re),
        .din1_im    (din1_im),
        .din2_re    (din2_re),
        .din2_im    (din2_im),
        .out_valid  (out_valid1),
        .out_ready  (out_ready),
        .dout1_re   (d1_sre),
        .dout1_im   (d1_sim),
        .dout2_re   (d1_dre),
        .dout2_im   (d1_dim),
        .ovf_sticky (ovf1),
        .ovf_clr    (ovf_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_din(input int a_re, input int a_im, input int b_re, input int b_im);
        for (int l = 0; l < LANES; l++) begin
            din1_re[l] = sample_t'(a_re);
            din1_im[l] = sample_t'(a_im);
            din2_re[l] = sample_t'(b_re);
            din2_im[l] = sample_t'(b_im);
        end
    endtask

    // Single beat; returns just after it has been loaded into S2.
    task automatic send_one(input int a_re, input int a_im, input int b_re, input int b_im,
                            input logic clr_at_s2);
        set_din(a_re, a_im, b_re, b_im);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        ovf_clr  = clr_at_s2;
        tick();
        ovf_clr  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int nrx;
        int nsent;
        n_checks  = 0;
        n_errors  = 0;
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        set_din(0, 0, 0, 0);
        tick();
        tick();
        check("rst_out_valid0", out_valid0, 0);
        check("rst_out_valid1", out_valid1, 0);
        check("rst_dout0", d0_sre[0], 0);
        check("rst_dout1", d1_dre[0], 0);
        check("rst_ovf1", ovf1, 0);
        rstn = 1'b1;
        tick();
        check("rst_in_ready0", in_ready0, 1);
        check("rst_in_ready1", in_ready1, 1);

        // Single beat latency and values
        set_din(100, 7, -30, 2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_not_yet", out_valid0, 0);
        tick();
        check("t1_valid", out_valid0, 1);
        check("t1_sum_re", d0_sre[0], 70);
        check("t1_diff_re", d0_dre[0], -130);
        check("t1_sum_im", d0_sim[0], 9);
        check("t1_diff_im", d0_dim[0], -5);
        check("t1_lane15", d0_dre[15], -130);
        check("t1_sc_sum_re", d1_sre[0], 35);
        check("t1_sc_diff_re", d1_dre[0], -65);
        check("t1_sc_sum_im", d1_sim[0], 5);
        check("t1_sc_diff_im", d1_dim[0], -2);
        tick();
        check("t1_one_cycle", out_valid0, 0);

        // Extremes
        send_one(-512, -512, 511, -512, 1'b0);
        check("t2_sum_re", d0_sre[0], -1);
        check("t2_diff_re", d0_dre[0], 1023);
        check("t2_sum_im", d0_sim[0], -1024);
        check("t2_diff_im", d0_dim[0], 0);
        check("t2_sc_sum_re", d1_sre[0], 0);
        check("t2_sc_sat", d1_dre[0], 511);
        check("t2_sc_sum_im", d1_sim[0], -512);
        check("t2_sc_diff_im", d1_dim[0], 0);
        check("t2_ovf_set", ovf1, 1);
        check("t2_ovf_tied", ovf0, 0);

        // Rounding
        send_one(3, 3, 4, 4, 1'b0);
        check("t3_sc_sum", d1_sre[0], 4);
        check("t3_sc_diff", d1_dre[0], 1);
        check("t3_sum", d0_sre[0], 7);
        check("t3_diff", d0_dre[0], 1);
        check("t3_ovf_held", ovf1, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t3_ovf_clr", ovf1, 0);

        // Set beats a simultaneous clear
        send_one(-512, 0, 511, 0, 1'b1);
        check("t5_set_wins", ovf1, 1);
        check("t5_sat", d1_dre[0], 511);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t5_clr_alone", ovf1, 0);

        // Backpressure: five beats, downstream stalls for cycles 3..7
        nrx   = 0;
        nsent = 0;
        for (int c = 0; c < 16; c++) begin
            out_ready = !(c >= 3 && c < 8);
            if (nsent < 5) begin
                set_din(10 * nsent, 0, 5, 0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 3 && c < 8) check("bp_in_ready", in_ready0, 0);
            if (c >= 8 && nrx < 5) check("bp_no_gap", out_valid0, 1);
            if (out_valid0) begin
                check("bp_sum", d0_sre[0], 5 + 10 * nrx);
                check("bp_diff", d0_dre[0], 5 - 10 * nrx);
                if (out_ready) nrx++;
            end
            if (in_valid && in_ready0) nsent++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", nrx, 5);

        // Reset with two beats held
        out_ready = 1'b0;
        set_din(-512, 0, 511, 0);
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        check("t6_held_valid", out_valid1, 1);
        check("t6_full", in_ready0, 0);
        check("t6_ovf_pre", ovf1, 1);
        rstn = 1'b0;
        tick();
        check("t6_out_valid", out_valid0, 0);
        check("t6_out_valid1", out_valid1, 0);
        check("t6_dout0", d0_dre[0], 0);
        check("t6_dout1", d1_dre[0], 0);
        check("t6_ovf", ovf1, 0);
        rstn      = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_flushed", out_valid0 | out_valid1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
